approximate_accuracy_controlable_multiplier: RTL and testbench
==============================================================

# approximate_accuracy_controlable_multiplier

Registered unsigned 8×8 approximate multiplier with run-time accuracy control. A 7-bit error-recovery vector selects, per low-order product column, exact or approximate accumulation. All-ones gives the exact product; clearing bits trades accuracy for a shorter carry chain. It sits in the approximate arithmetic unit set beside the exact multiplier and feeds the execution datapath.

## Interface
- `len`, default 8: operand width. Product width is 2·len; Er width is len−1.
- `CLK`  in  1: clock. Rising-edge active.
- `reset`  in  1: reset. Asynchronous, active-low. Clears the output register.
- `Er`  in  len−1 (7): error-recovery vector. `Er[k]=1` means column k+1 is exact.
- `Multiplicand`  in  len (8): unsigned operand A.
- `Multiplier`  in  len (8): unsigned operand B.
- `Product`  out  2·len (16): registered unsigned result.
- Port order: `CLK`, `reset`, `Er`, `Multiplicand`, `Multiplier`, `Product`.

## Operation
- **Partial products:** pp(i,j) = A[i] & B[j]. It belongs to column c = i + j, for c = 0..2·len−2.
- **Column accumulation:** process columns c = 0 .. 2·len−1 in order, with incoming carry count C_0 = 0.
  - Column sum S_c = (number of set pp bits in column c) + C_c, an integer.
  - Column 2·len−1 has no partial products; only the carry enters it.
- **Exact column:** Product[c] = S_c mod 2 and C_{c+1} = floor(S_c / 2).
  - Applies to column 0, to all columns c ≥ len, and to any column 1..len−1 whose Er bit is set.
- **Approximate column:** applies to c in 1..len−1 when `Er[c−1]=0`.
  - Product[c] = 1 if S_c ≠ 0, else 0 (OR-compression).
  - C_{c+1} = 0: the column generates no carry.
- **Er = all ones:** Product = A·B exactly, for all operands.
- **Er = 0:** the low len bits are bitwise ORs of their column bits. The high half receives no carry from the low half.
- **Carries:** any carry out of column 2·len−1 is discarded. Product is always exactly 2·len bits.
- **Structure:** a combinational partial-product array and compression tree built from full/half adders, with OR-compressors in the controlled columns. Output register only.
- **Er timing:** Er is a data input, sampled on the same edge as the operands. It may change every cycle.

## Timing
- **Latency:** one cycle. Operands and Er present before rising edge N give Product valid after edge N.
- **Throughput:** one result per cycle. There is no handshake and no valid signal.
- **Reset:** while `reset=0`, Product = 16'h0000 immediately (asynchronous) and holds through any clock edges.
  - On release, the first rising edge with `reset=1` loads the product of the current inputs.
- **Reset mid-operation:** the pending result is lost. There is no recovery or replay.
- **Output stability:** Product changes only on rising CLK or on reset assertion. Input glitches between edges are invisible.

## Test plan
- **Exact mode:** Er=7'h7F, A=255, B=255 → Product=65025 (16'hFE01) one cycle later. Also check 20 random pairs against A·B.
- **Full approximation:** Er=7'h00, A=255, B=255 → Product=16'hF7FF (63487). A=3, B=3 → Product=7.
- **Per-column control:** A=3, B=3 → Product=5 with Er=7'h01, 9 with Er=7'h7F, 7 with Er=7'h00.
- **Zero and identity:** A=0, B=any, any Er → 0. A=1, B=200, Er=7'h00 → 200 (single pp per column, no error).
- **Reset:** load A=255, B=255 (Er=7'h7F). Assert reset mid-cycle → Product=0 at once and stays 0 across edges. Deassert → the next edge gives 16'hFE01.
- **Back-to-back:** change A, B and Er every cycle. Each Product equals the model of the previous cycle's inputs, with no cross-cycle mixing.

Source files
------------

// File: rtl/approximate_accuracy_controlable_multiplier.sv
// Registered unsigned len x len multiplier whose low columns can
// switch per cycle between exact adding and carry-free OR compression.
module approximate_accuracy_controlable_multiplier #(
  parameter int len = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [len-2:0]    Er,
  input  logic [len-1:0]    Multiplicand,
  input  logic [len-1:0]    Multiplier,
  output logic [2*len-1:0]  Product
);

  localparam int PW = 2 * len;
  localparam int SW = $clog2(4 * len) + 1;

  logic [len-1:0] pp [len];
  logic [PW-1:0]  exact_col;
  logic [PW-1:0]  prod_d;
  logic [SW-1:0]  col_sum;
  logic [SW-1:0]  carry;

  always_comb begin
    for (int i = 0; i < len; i++) begin
      for (int j = 0; j < len; j++) begin
        pp[i][j] = Multiplicand[i] & Multiplier[j];
      end
    end
  end

  // Column 0 and the whole high half are always exact.
  assign exact_col = {{len{1'b1}}, Er, 1'b1};

  always_comb begin
    carry   = '0;
    col_sum = '0;
    prod_d  = '0;
    for (int c = 0; c < PW; c++) begin
      col_sum = carry;
      for (int i = 0; i < len; i++) begin
        for (int j = 0; j < len; j++) begin
          if (i + j == c) begin
            col_sum = col_sum + SW'(pp[i][j]);
          end
        end
      end
      if (exact_col[c]) begin
        prod_d[c] = col_sum[0];
        carry     = col_sum >> 1;
      end else begin
        prod_d[c] = |col_sum;
        carry     = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      Product <= '0;
    end else begin
      Product <= prod_d;
    end
  end

endmodule

// File: tb/tb_approximate_accuracy_controlable_multiplier.sv
// Bench for the accuracy-controlled multiplier: constant vectors,
// random exact/approximate streams through a scoreboard, and reset.
module tb_approximate_accuracy_controlable_multiplier;

  logic        clk;
  logic        rst_n;
  logic [6:0]  er;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] prod;

  int checks;
  int failures;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [6:0]  er;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } sb_t;

  sb_t  sb_q [$];
  vec_t tbl  [8];

  approximate_accuracy_controlable_multiplier #(.len(8)) dut (
    .CLK          (clk),
    .reset        (rst_n),
    .Er           (er),
    .Multiplicand (a),
    .Multiplier   (b),
    .Product      (prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(
    input logic [7:0] ma,
    input logic [7:0] mb,
    input logic [6:0] mer
  );
    logic [15:0] p;
    logic [15:0] ex;
    int          cy;
    int          s;
    p  = '0;
    ex = {8'hFF, mer, 1'b1};
    cy = 0;
    for (int c = 0; c < 16; c++) begin
      s = cy;
      for (int i = 0; i < 8; i++) begin
        if (c - i >= 0 && c - i < 8) begin
          s = s + int'(ma[i] & mb[c-i]);
        end
      end
      if (ex[c]) begin
        p[c] = (s % 2) == 1;
        cy   = s / 2;
      end else begin
        p[c] = (s != 0);
        cy   = 0;
      end
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic pop_check();
    sb_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, prod, e.exp);
    end
  endtask

  // Compare the result of the previous cycle, then drive the next one.
  task automatic step(input logic [7:0] va, input logic [7:0] vb,
                      input logic [6:0] ver, input logic [15:0] vexp,
                      input string name);
    sb_t e;
    @(negedge clk);
    pop_check();
    a  = va;
    b  = vb;
    er = ver;
    e.exp  = vexp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic flush();
    @(negedge clk);
    pop_check();
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [6:0] rer;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    a        = 8'hFF;
    b        = 8'hFF;
    er       = 7'h7F;

    tbl[0] = '{8'd255, 8'd255, 7'h7F, 16'hFE01};
    tbl[1] = '{8'd255, 8'd255, 7'h00, 16'hF7FF};
    tbl[2] = '{8'd3,   8'd3,   7'h00, 16'd7};
    tbl[3] = '{8'd3,   8'd3,   7'h01, 16'd5};
    tbl[4] = '{8'd3,   8'd3,   7'h7F, 16'd9};
    tbl[5] = '{8'd0,   8'd171, 7'h55, 16'd0};
    tbl[6] = '{8'd1,   8'd200, 7'h00, 16'd200};
    tbl[7] = '{8'd0,   8'd255, 7'h00, 16'd0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", prod, 16'h0000);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      step(tbl[k].a, tbl[k].b, tbl[k].er, tbl[k].exp,
           $sformatf("vec%0d", k));
    end
    flush();

    for (int k = 0; k < 20; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      step(ra, rb, 7'h7F, 16'(ra) * 16'(rb),
           $sformatf("exact%0d", k));
    end
    flush();

    for (int k = 0; k < 20; k++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rer = 7'($urandom_range(0, 127));
      step(ra, rb, rer, model(ra, rb, rer),
           $sformatf("b2b%0d", k));
    end
    flush();

    step(8'd255, 8'd255, 7'h7F, 16'hFE01, "pre_reset");
    flush();
    #2 rst_n = 1'b0;
    #1 check("reset_async", prod, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_edges", prod, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", prod, 16'hFE01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
